// File: rtl/icode_fetch_unit_pkg.sv
// Shared types and constants for the instruction-code fetch unit.
// Holds the FSM encoding and the ICODE and address widths.
package icode_fetch_unit_pkg;

  localparam int ICODE_W = 8;
  localparam int ADDR_W  = 4;
  localparam logic [ICODE_W-1:0] HALT_CODE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_e;

  function automatic logic is_active(input fetch_state_e s);
    return (s == S_FETCH) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/icode_fifo.sv
// Synchronous prefetch FIFO with a flush input.
// A simultaneous push and pop is accepted even when the FIFO is full.
module icode_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  // The head is masked so a drained FIFO always presents zero.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= din;
  end

endmodule

// File: rtl/icode_fetch_unit.sv
// Instruction-code fetch unit: program memory, one-deep read pipe and a
// prefetch FIFO feeding ICODE to the processor until HALT_CODE is seen.
module icode_fetch_unit
  import icode_fetch_unit_pkg::*;
#(
  parameter int                 PROG_DEPTH = 16,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ICODE_W-1:0] HALT_CODE  = HALT_CODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [ICODE_W-1:0] prog_data,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               icode_ready,
  output logic [ICODE_W-1:0] ICODE,
  output logic               icode_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic               rd_vld;
  logic [ICODE_W-1:0] rd_data;
  logic [ICODE_W-1:0] mem [PROG_DEPTH];

  logic [CW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic          active, go, flush, halt_push, push, pop, issue;
  logic [CW:0]   occ;

  assign active    = is_active(state);
  assign go        = start && !active;
  assign flush     = go || (redirect_valid && active);
  assign halt_push = rd_vld && (rd_data == HALT_CODE);
  assign push      = rd_vld && !flush;
  assign pop       = icode_valid && icode_ready && !flush;

  // Count the in-flight read as occupied so it always has a slot to land in.
  assign occ   = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_vld};
  assign issue = (state == S_FETCH) && !flush && !halt_push && !fifo_full &&
                 (occ < (CW+1)'(FIFO_DEPTH));

  assign icode_valid = !fifo_empty;
  assign pc_out      = pc;
  assign busy        = active;
  assign done        = (state == S_DONE);

  // Program memory is not reset; writes are locked out while fetching.
  always_ff @(posedge clk) begin
    if (prog_we && !active) mem[prog_addr] <= prog_data;
    if (issue)              rd_data <= mem[pc];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) pc <= pc + 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH: begin
          if (redirect_valid) begin
            state <= S_FETCH;
            pc    <= redirect_addr;
          end else if (halt_push) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (redirect_valid) begin
            state <= S_FETCH;
            pc    <= redirect_addr;
          end else if (fifo_empty) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  icode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ICODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (rd_data),
    .dout  (ICODE),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule
